aes_decipher: RTL and testbench

//   Iterative AES-128 inverse cipher (FIPS-197 sec 5.3), one round per clock. Receive-side

---
 rtl/aes_pkg.sv | 61 ++++++
 rtl/aes_inv_sbox.sv | 27 ++
 rtl/aes_decipher.sv | 96 +++++++++
 tb/tb_aes_decipher.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// AES types and GF(2^8) helpers shared between the encipher and decipher datapaths.
package aes_pkg;

  typedef logic [127:0] aes_state_t;

  localparam int unsigned NR_128 = 10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    COMP = 2'd1
  } dec_fsm_t;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Shift-and-add multiply reduced by 0x11B.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // Byte (row r, col c) sits at index r + 4c, byte 0 in the top bits.
  function automatic aes_state_t inv_shift_rows(input aes_state_t s);
    aes_state_t o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c-r+4)%4)) -: 8];
      end
    end
    return o;
  endfunction

  function automatic aes_state_t inv_mix_columns(input aes_state_t s);
    aes_state_t o;
    logic [7:0] a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 32] = {
        gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09),
        gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d),
        gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b),
        gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e)
      };
    end
    return o;
  endfunction

endpackage

// File: rtl/aes_inv_sbox.sv
// Combinational AES inverse S-box: inverse affine map followed by GF(2^8) inversion (x^254).
module aes_inv_sbox
  import aes_pkg::*;
(
  input  logic [7:0] in_byte,
  output logic [7:0] out_c
);

  logic [7:0] pre;
  logic [7:0] x2, x4, x8, x16, x32, x64, x128;

  // x^254 = x^2 * x^4 * ... * x^128, which maps 0 to 0 as AES requires.
  always_comb begin
    pre   = {in_byte[6:0], in_byte[7]} ^ {in_byte[4:0], in_byte[7:5]} ^
            {in_byte[1:0], in_byte[7:2]} ^ 8'h05;
    x2    = gf_mul(pre, pre);
    x4    = gf_mul(x2, x2);
    x8    = gf_mul(x4, x4);
    x16   = gf_mul(x8, x8);
    x32   = gf_mul(x16, x16);
    x64   = gf_mul(x32, x32);
    x128  = gf_mul(x64, x64);
    out_c = gf_mul(gf_mul(gf_mul(x2, x4), gf_mul(x8, x16)),
                   gf_mul(gf_mul(x32, x64), x128));
  end

endmodule

// File: rtl/aes_decipher.sv
// Iterative AES-128 inverse cipher, one round per clock; round keys are fetched by index 10..0.
module aes_decipher
  import aes_pkg::*;
#(
  parameter int unsigned NR     = NR_128,
  parameter int unsigned KIDX_W = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_init,
  input  logic [127:0]      i_cipher,
  input  logic [127:0]      i_round_key,
  output logic [KIDX_W-1:0] o_key_idx,
  output logic [127:0]      o_plain,
  output logic              o_done,
  output logic              o_busy
);

  dec_fsm_t          fsm_q, fsm_d;
  aes_state_t        state_q, state_d;
  logic [KIDX_W-1:0] rnd_q, rnd_d;
  logic [KIDX_W-1:0] kidx_d;
  aes_state_t        plain_d;
  logic              done_d, busy_d;

  aes_state_t        sr_c, sb_c, t_c;

  assign sr_c = inv_shift_rows(state_q);

  for (genvar g = 0; g < 16; g++) begin : g_sbox
    aes_inv_sbox u_sbox (
      .in_byte (sr_c[127-8*g -: 8]),
      .out_c   (sb_c[127-8*g -: 8])
    );
  end

  assign t_c = sb_c ^ i_round_key;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      fsm_q     <= IDLE;
      state_q   <= '0;
      rnd_q     <= '0;
      o_key_idx <= KIDX_W'(NR);
      o_plain   <= '0;
      o_done    <= 1'b0;
      o_busy    <= 1'b0;
    end else begin
      fsm_q     <= fsm_d;
      state_q   <= state_d;
      rnd_q     <= rnd_d;
      o_key_idx <= kidx_d;
      o_plain   <= plain_d;
      o_done    <= done_d;
      o_busy    <= busy_d;
    end
  end

  // Key index is registered one cycle ahead so it always matches the round in progress.
  always_comb begin
    fsm_d   = fsm_q;
    state_d = state_q;
    rnd_d   = rnd_q;
    kidx_d  = KIDX_W'(NR);
    plain_d = o_plain;
    done_d  = o_done;
    busy_d  = o_busy;
    case (fsm_q)
      IDLE: begin
        done_d = 1'b0;
        if (i_init) begin
          state_d = i_cipher ^ i_round_key;
          rnd_d   = KIDX_W'(NR - 1);
          kidx_d  = KIDX_W'(NR - 1);
          busy_d  = 1'b1;
          fsm_d   = COMP;
        end
      end
      COMP: begin
        done_d = 1'b0;
        if (rnd_q != '0) begin
          state_d = inv_mix_columns(t_c);
          rnd_d   = rnd_q - KIDX_W'(1);
          kidx_d  = rnd_q - KIDX_W'(1);
        end else begin
          plain_d = t_c;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          fsm_d   = IDLE;
        end
      end
      default: fsm_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_aes_decipher.sv
// Scoreboard bench for aes_decipher: FIPS-197 vectors, control corner cases, random loopback.
module tb_aes_decipher;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         init;
  logic [127:0] cipher;
  logic [127:0] rkey;
  logic [3:0]   key_idx;
  logic [127:0] plain;
  logic         done;
  logic         busy;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;

  logic [127:0] exp_q[$];
  logic [127:0] rk [11];
  logic [7:0]   sbox [256];

  localparam logic [127:0] K_C1  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT_C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PT_C1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] K_B   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;

  aes_decipher #(.NR(10), .KIDX_W(4)) dut (
    .i_clk       (clk),
    .i_rst       (rst_n),
    .i_init      (init),
    .i_cipher    (cipher),
    .i_round_key (rkey),
    .o_key_idx   (key_idx),
    .o_plain     (plain),
    .o_done      (done),
    .o_busy      (busy)
  );

  always #5 clk = ~clk;

  // Key store: combinational lookup by the requested index.
  assign rkey = (key_idx <= 4'd10) ? rk[key_idx] : '0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  // Forward S-box from brute-force inverse plus affine map.
  task automatic build_sbox();
    logic [7:0] inv;
    logic [7:0] b;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      b = inv;
      sbox[x] = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^
                {b[3:0], b[7:4]} ^ 8'h63;
    end
  endtask

  task automatic set_key(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]} ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  function automatic logic [127:0] encrypt(input logic [127:0] pt);
    logic [127:0] s;
    logic [127:0] o;
    logic [7:0] a0, a1, a2, a3;
    s = pt ^ rk[0];
    for (int r = 1; r <= 10; r++) begin
      for (int k = 0; k < 16; k++) s[127-8*k -: 8] = sbox[s[127-8*k -: 8]];
      for (int c = 0; c < 4; c++)
        for (int row = 0; row < 4; row++)
          o[127-8*(row+4*c) -: 8] = s[127-8*(row+4*((c+row)%4)) -: 8];
      if (r != 10) begin
        for (int c = 0; c < 4; c++) begin
          a0 = o[127-32*c -: 8];
          a1 = o[119-32*c -: 8];
          a2 = o[111-32*c -: 8];
          a3 = o[103-32*c -: 8];
          o[127-32*c -: 32] = {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
                               a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
                               a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
                               xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
        end
      end
      s = o ^ rk[r];
    end
    return s;
  endfunction

  // Issue a block: called just after a rising edge; the next edge accepts it.
  task automatic start(input logic [127:0] ct, input logic [127:0] pt);
    cipher = ct;
    init   = 1'b1;
    exp_q.push_back(pt);
  endtask

  task automatic wait_done(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 30 && !ok; i++) begin
      if (done) ok = 1'b1;
      else begin
        @(posedge clk);
        #1;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout actual=no_done required=done", name);
    end
  endtask

  // Monitor: every completion pops one expected plaintext.
  always @(negedge clk) begin
    if (rst_n && done) begin
      done_cnt++;
      if (exp_q.size() == 0) chk("unexpected_done", plain, 128'hx);
      else chk("plain", plain, exp_q.pop_front());
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int d0;
    logic [127:0] key, pt, ct;
    rst_n  = 1'b0;
    init   = 1'b0;
    cipher = '0;
    build_sbox();
    set_key(K_C1);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_plain", plain, 128'h0);
    chk("rst_done", 128'(done), 128'h0);
    chk("rst_busy", 128'(busy), 128'h0);
    chk("rst_key_idx", 128'(key_idx), 128'd10);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // FIPS-197 C.1 with key-index sequence and latency
    start(CT_C1, PT_C1);
    for (int k = 0; k <= 10; k++) begin
      @(negedge clk);
      chk("key_idx_seq", 128'(key_idx), 128'(10 - k));
      if (k == 1) chk("busy_run", 128'(busy), 128'h1);
      @(posedge clk);
      #1;
      init = 1'b0;
    end
    chk("latency_done", 128'(done), 128'h1);
    repeat (2) @(posedge clk);
    #1;

    // FIPS-197 App. B, then C.1 accepted in the done cycle
    set_key(K_B);
    start(CT_B, PT_B);
    @(posedge clk);
    #1;
    init = 1'b0;
    wait_done("app_b");
    chk("busy_gap", 128'(busy), 128'h0);
    set_key(K_C1);
    start(CT_C1, PT_C1);
    @(posedge clk);
    #1;
    init = 1'b0;
    chk("busy_rise", 128'(busy), 128'h1);
    chk("done_drop", 128'(done), 128'h0);
    wait_done("b2b");
    @(posedge clk);
    #1;

    // i_init pulse and i_cipher change mid-operation
    d0 = done_cnt;
    start(CT_C1, PT_C1);
    @(posedge clk);
    #1;
    init = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    cipher = 128'hdeadbeef_01234567_89abcdef_cafef00d;
    init   = 1'b1;
    @(posedge clk);
    #1;
    init   = 1'b0;
    cipher = 128'h0;
    wait_done("mid_init");
    repeat (15) @(posedge clk);
    #1;
    chk("one_done", 128'(done_cnt - d0), 128'd1);

    // Reset at COMP cycle 5
    set_key(K_B);
    start(CT_B, PT_B);
    @(posedge clk);
    #1;
    init = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    d0 = done_cnt;
    rst_n = 1'b0;
    exp_q.delete();
    @(posedge clk);
    #1;
    chk("abort_plain", plain, 128'h0);
    chk("abort_busy", 128'(busy), 128'h0);
    chk("abort_key_idx", 128'(key_idx), 128'd10);
    rst_n = 1'b1;
    repeat (15) @(posedge clk);
    #1;
    chk("abort_no_done", 128'(done_cnt - d0), 128'd0);
    chk("abort_plain_held", plain, 128'h0);
    start(CT_B, PT_B);
    @(posedge clk);
    #1;
    init = 1'b0;
    wait_done("after_abort");
    @(posedge clk);
    #1;

    // Random loopback through the bench encipher
    for (int n = 0; n < 1000; n++) begin
      key = {$urandom, $urandom, $urandom, $urandom};
      pt  = {$urandom, $urandom, $urandom, $urandom};
      set_key(key);
      ct = encrypt(pt);
      start(ct, pt);
      @(posedge clk);
      #1;
      init = 1'b0;
      wait_done("loopback");
      @(posedge clk);
      #1;
    end

    repeat (3) @(posedge clk);
    #1;
    chk("queue_empty", 128'(exp_q.size()), 128'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
